// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority) and buffered NoC writes.
// Optional same-cycle NI bypass when the buffer is empty is enabled by defining RFARB_BYPASS_EN.
module regfile_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_STARVE = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_wb_we,
    input  logic [ADDR_W-1:0]             i_wb_rd,
    input  logic [DATA_W-1:0]             i_wb_wd,
    input  logic                          i_ni_valid,
    input  logic [ADDR_W-1:0]             i_ni_rd,
    input  logic [DATA_W-1:0]             i_ni_wd,
    output logic                          o_ni_ready,
    output logic                          o_rf_we,
    output logic [ADDR_W-1:0]             o_rf_rd,
    output logic [DATA_W-1:0]             o_rf_wd,
    output logic                          o_stall_req,
    output logic [$clog2(FIFO_DEPTH):0]   o_ni_pending
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = $clog2(MAX_STARVE + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    logic [ADDR_W-1:0] r_fifo_rd [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_wd [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [STV_W-1:0]  r_starve;
    state_t            r_state;

    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic              w_pop;
    logic              w_push;
    logic              w_bypass;
    logic              w_ni_ready;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_rd;
    logic [DATA_W-1:0] w_sel_wd;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [STV_W-1:0]  w_starve_nxt;
    state_t            w_state_nxt;

    // Handshake and grant: writeback wins, then FIFO head, then (optionally) the live NI request.
    always_comb begin
        w_fifo_empty = (r_count == {CNT_W{1'b0}});
        w_fifo_full  = (r_count == CNT_W'(FIFO_DEPTH));
        // Discarded entries must not reach the register file while reset is held.
        w_pop        = !i_rst && !i_wb_we && !w_fifo_empty;
`ifdef RFARB_BYPASS_EN
        w_bypass     = !i_rst && !i_wb_we && w_fifo_empty && i_ni_valid;
`else
        w_bypass     = 1'b0;
`endif
        w_ni_ready   = !i_rst && (!w_fifo_full || w_pop);
        w_push       = i_ni_valid && w_ni_ready && !w_bypass;
        w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

        w_sel_we = 1'b0;
        w_sel_rd = {ADDR_W{1'b0}};
        w_sel_wd = {DATA_W{1'b0}};
        if (i_wb_we) begin
            w_sel_we = 1'b1;
            w_sel_rd = i_wb_rd;
            w_sel_wd = i_wb_wd;
        end else if (w_pop) begin
            w_sel_we = 1'b1;
            w_sel_rd = r_fifo_rd[r_head];
            w_sel_wd = r_fifo_wd[r_head];
        end else if (w_bypass) begin
            w_sel_we = 1'b1;
            w_sel_rd = i_ni_rd;
            w_sel_wd = i_ni_wd;
        end else begin
            w_sel_we = 1'b0;
        end
    end

    assign o_ni_ready   = w_ni_ready;
    // r0 is hardwired zero: the grant is consumed but never written.
    assign o_rf_we      = w_sel_we && (w_sel_rd != {ADDR_W{1'b0}});
    assign o_rf_rd      = w_sel_rd;
    assign o_rf_wd      = w_sel_wd;
    assign o_stall_req  = (r_state == ST_STALL);
    assign o_ni_pending = r_count;

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_rd[r_tail] <= i_ni_rd;
            r_fifo_wd[r_tail] <= i_ni_wd;
        end
    end

    // Starvation FSM next-state: count blocked cycles, request a stall after MAX_STARVE of them.
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        case (r_state)
            ST_IDLE: begin
                w_starve_nxt = {STV_W{1'b0}};
                if (w_count_nxt != {CNT_W{1'b0}}) begin
                    w_state_nxt = ST_PEND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (w_pop) begin
                    w_starve_nxt = {STV_W{1'b0}};
                    w_state_nxt  = (w_count_nxt == {CNT_W{1'b0}}) ? ST_IDLE : ST_PEND;
                end else if (r_starve == STV_W'(MAX_STARVE - 1)) begin
                    w_state_nxt  = ST_STALL;
                end else begin
                    w_starve_nxt = r_starve + STV_W'(1);
                end
            end
            ST_STALL: begin
                if (w_pop) begin
                    w_starve_nxt = {STV_W{1'b0}};
                    w_state_nxt  = (w_count_nxt == {CNT_W{1'b0}}) ? ST_IDLE : ST_PEND;
                end else begin
                    w_state_nxt  = ST_STALL;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_starve_nxt = {STV_W{1'b0}};
            end
        endcase
    end

    // Pointer, occupancy and FSM state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head   <= {PTR_W{1'b0}};
            r_tail   <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_starve <= {STV_W{1'b0}};
            r_state  <= ST_IDLE;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count  <= w_count_nxt;
            r_starve <= w_starve_nxt;
            r_state  <= w_state_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (default build, no bypass).
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        ni_valid;
    logic [4:0]  ni_rd;
    logic [31:0] ni_wd;
    logic        ni_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        stall_req;
    logic [2:0]  ni_pending;

    int errors = 0;
    int checks = 0;

    regfile_write_arbiter dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wb_we      (wb_we),
        .i_wb_rd      (wb_rd),
        .i_wb_wd      (wb_wd),
        .i_ni_valid   (ni_valid),
        .i_ni_rd      (ni_rd),
        .i_ni_wd      (ni_wd),
        .o_ni_ready   (ni_ready),
        .o_rf_we      (rf_we),
        .o_rf_rd      (rf_rd),
        .o_rf_wd      (rf_wd),
        .o_stall_req  (stall_req),
        .o_ni_pending (ni_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; wb_we = 1'b0; wb_rd = 5'd0; wb_wd = 32'd0;
        ni_valid = 1'b0; ni_rd = 5'd0; ni_wd = 32'd0;

        // 1: reset for two cycles, then idle
        tick(); tick();
        rst = 1'b0;
        settle();
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_pending", {29'd0, ni_pending}, 32'd0);
        chk("rst_ni_ready", {31'd0, ni_ready}, 32'd1);
        tick();

        // 2: NI write r5 lands one cycle after acceptance
        ni_valid = 1'b1; ni_rd = 5'd5; ni_wd = 32'hDEADBEEF;
        settle();
        chk("t2_ready_N", {31'd0, ni_ready}, 32'd1);
        chk("t2_rf_we_N", {31'd0, rf_we}, 32'd0);
        tick();
        ni_valid = 1'b0;
        settle();
        chk("t2_pending", {29'd0, ni_pending}, 32'd1);
        chk("t2_rf_we_N1", {31'd0, rf_we}, 32'd1);
        chk("t2_rf_rd", {27'd0, rf_rd}, 32'd5);
        chk("t2_rf_wd", rf_wd, 32'hDEADBEEF);
        tick();
        chk("t2_drained", {29'd0, ni_pending}, 32'd0);
        chk("t2_idle_we", {31'd0, rf_we}, 32'd0);

        // 3: wb and NI to r3 in the same cycle -> wb first, NI next
        wb_we = 1'b1; wb_rd = 5'd3; wb_wd = 32'h11;
        ni_valid = 1'b1; ni_rd = 5'd3; ni_wd = 32'h22;
        settle();
        chk("t3_wb_we", {31'd0, rf_we}, 32'd1);
        chk("t3_wb_rd", {27'd0, rf_rd}, 32'd3);
        chk("t3_wb_wd", rf_wd, 32'h11);
        tick();
        wb_we = 1'b0; ni_valid = 1'b0;
        settle();
        chk("t3_ni_we", {31'd0, rf_we}, 32'd1);
        chk("t3_ni_rd", {27'd0, rf_rd}, 32'd3);
        chk("t3_ni_wd", rf_wd, 32'h22);
        tick();
        chk("t3_done_we", {31'd0, rf_we}, 32'd0);

        // 4: starvation -> stall_req after 8 blocked cycles
        wb_we = 1'b1; wb_rd = 5'd7; wb_wd = 32'hA5;
        ni_valid = 1'b1; ni_rd = 5'd9; ni_wd = 32'h99;
        tick();
        ni_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("t4_nostall_%0d", i), {31'd0, stall_req}, 32'd0);
            tick();
        end
        chk("t4_stall", {31'd0, stall_req}, 32'd1);
        chk("t4_pending", {29'd0, ni_pending}, 32'd1);
        chk("t4_wb_wins", rf_wd, 32'hA5);
        tick();
        chk("t4_stall_hold", {31'd0, stall_req}, 32'd1);
        wb_we = 1'b0;
        settle();
        chk("t4_pop_we", {31'd0, rf_we}, 32'd1);
        chk("t4_pop_rd", {27'd0, rf_rd}, 32'd9);
        chk("t4_pop_wd", rf_wd, 32'h99);
        tick();
        chk("t4_stall_drop", {31'd0, stall_req}, 32'd0);
        chk("t4_empty", {29'd0, ni_pending}, 32'd0);

        // 5: fill the FIFO under continuous wb, then drain in order
        wb_we = 1'b1; wb_rd = 5'd1; wb_wd = 32'h100;
        for (int i = 0; i < 4; i++) begin
            ni_valid = 1'b1; ni_rd = 5'(10 + i); ni_wd = 32'h200 + 32'(i);
            settle();
            chk($sformatf("t5_ready_%0d", i), {31'd0, ni_ready}, 32'd1);
            tick();
        end
        ni_rd = 5'd20; ni_wd = 32'h300;
        settle();
        chk("t5_full_ready", {31'd0, ni_ready}, 32'd0);
        chk("t5_full_pend", {29'd0, ni_pending}, 32'd4);
        tick();
        chk("t5_no_overfill", {29'd0, ni_pending}, 32'd4);
        wb_we = 1'b0; ni_valid = 1'b0;
        settle();
        chk("t5_full_pop_ready", {31'd0, ni_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("t5_we_%0d", i), {31'd0, rf_we}, 32'd1);
            chk($sformatf("t5_rd_%0d", i), {27'd0, rf_rd}, 32'(10 + i));
            chk($sformatf("t5_wd_%0d", i), rf_wd, 32'h200 + 32'(i));
            tick();
        end
        chk("t5_drained", {29'd0, ni_pending}, 32'd0);
        chk("t5_idle_we", {31'd0, rf_we}, 32'd0);

        // 6a: NI write to r0 pops without writing; wb to r0 also suppressed
        ni_valid = 1'b1; ni_rd = 5'd0; ni_wd = 32'h55;
        tick();
        ni_valid = 1'b0;
        settle();
        chk("t6_r0_pend", {29'd0, ni_pending}, 32'd1);
        chk("t6_r0_we", {31'd0, rf_we}, 32'd0);
        tick();
        chk("t6_r0_popped", {29'd0, ni_pending}, 32'd0);
        wb_we = 1'b1; wb_rd = 5'd0; wb_wd = 32'h77;
        settle();
        chk("t6_wb_r0_we", {31'd0, rf_we}, 32'd0);

        // 6b: reset with three entries pending discards them
        wb_rd = 5'd2;
        for (int i = 0; i < 3; i++) begin
            ni_valid = 1'b1; ni_rd = 5'(4 + i); ni_wd = 32'h400 + 32'(i);
            tick();
        end
        ni_valid = 1'b0;
        settle();
        chk("t6_pend3", {29'd0, ni_pending}, 32'd3);
        wb_we = 1'b0; rst = 1'b1;
        settle();
        chk("t6_rst_no_write", {31'd0, rf_we}, 32'd0);
        tick();
        rst = 1'b0;
        settle();
        chk("t6_rst_pend", {29'd0, ni_pending}, 32'd0);
        chk("t6_rst_we", {31'd0, rf_we}, 32'd0);
        chk("t6_rst_ready", {31'd0, ni_ready}, 32'd1);
        tick();
        chk("t6_after_we", {31'd0, rf_we}, 32'd0);
        chk("t6_after_stall", {31'd0, stall_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
